// File: rtl/aes_pkg.sv
// aes_pkg: AES forward S-box, round-constant table and RotWord helper
package aes_pkg;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_single_round.sv
// aes_key_single_round: one registered AES-128 key-schedule round
module aes_key_single_round
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clk_en_i,
  input  logic [7:0]   rcon,
  input  logic [31:0]  iv,
  input  logic [127:0] key_i,
  output logic [127:0] key_o,
  output logic         key_valid_o
);

  logic [31:0]  w_rot, w_sub, w_temp, w_n0, w_n1, w_n2, w_n3;
  logic [127:0] r_key;
  logic         r_valid;

  assign w_rot = rot_word(iv);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.i_byte(w_rot[8*g +: 8]), .o_byte(w_sub[8*g +: 8]));
  end

  assign w_temp = w_sub ^ {rcon, 24'h0};
  assign w_n0   = key_i[127:96] ^ w_temp;
  assign w_n1   = w_n0 ^ key_i[95:64];
  assign w_n2   = w_n1 ^ key_i[63:32];
  assign w_n3   = w_n2 ^ key_i[31:0];

  // capture the next key on enabled edges; valid tracks whether this edge was enabled
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_key   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= clk_en_i;
      if (clk_en_i) r_key <= {w_n0, w_n1, w_n2, w_n3};
    end
  end

  assign key_o       = r_key;
  assign key_valid_o = r_valid;

endmodule

// File: tb/tb_aes_key_single_round.sv
// tb_aes_key_single_round: randomized check against a GF(2^8)-derived key-schedule model
module tb_aes_key_single_round;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         clk_en_i = 1'b0;
  logic [7:0]   rcon = '0;
  logic [31:0]  iv = '0;
  logic [127:0] key_i = '0;
  logic [127:0] key_o;
  logic         key_valid_o;

  int errs = 0;
  int checks = 0;

  logic [7:0]   m_sbox [256];
  logic [127:0] m_key = '0;
  logic         m_valid = 1'b0;

  aes_key_single_round dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i), .rcon(rcon),
    .iv(iv), .key_i(key_i), .key_o(key_o), .key_valid_o(key_valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [31:0] v, input logic [7:0] rc);
    logic [31:0] r, t, n0, n1, n2, n3;
    r = {v[23:0], v[31:24]};
    t = {m_sbox[r[31:24]] ^ rc, m_sbox[r[23:16]], m_sbox[r[15:8]], m_sbox[r[7:0]]};
    n0 = k[127:96] ^ t;
    n1 = n0 ^ k[95:64];
    n2 = n1 ^ k[63:32];
    n3 = n2 ^ k[31:0];
    return {n0, n1, n2, n3};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model state: follows reset and enabled edges
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_key = '0;
      m_valid = 1'b0;
    end else begin
      m_valid = clk_en_i;
      if (clk_en_i) m_key = next_key(key_i, iv, rcon);
    end
  end

  // compare DUT against the model every cycle, away from the active edge
  always @(negedge clk_i) begin
    chk("model_key", key_o, m_key);
    chk("model_valid", {127'h0, key_valid_o}, {127'h0, m_valid});
  end

  task automatic drive(input logic en, input logic [127:0] k, input logic [31:0] v, input logic [7:0] rc);
    @(negedge clk_i);
    clk_en_i = en;
    key_i = k;
    iv = v;
    rcon = rc;
  endtask

  task automatic edge_check(input string name, input logic [127:0] ek, input logic ev);
    @(posedge clk_i);
    #1;
    chk({name, "_key"}, key_o, ek);
    chk({name, "_valid"}, {127'h0, key_valid_o}, {127'h0, ev});
  endtask

  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] rk;
    build_sbox();
    chk("model_sbox00", {120'h0, m_sbox[0]}, 128'h63);
    chk("model_sbox53", {120'h0, m_sbox[8'h53]}, 128'hed);
    chk("model_round1", next_key(K0, K0[31:0], 8'h01), K1);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 3; i++)
      drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, $urandom, 8'($urandom));
    edge_check("reset_hold", 128'h0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    clk_en_i = 1'b1;
    key_i = K0;
    iv = K0[31:0];
    rcon = 8'h01;
    #1;
    chk("release_valid_low", {127'h0, key_valid_o}, 128'h0);
    edge_check("round1", K1, 1'b1);
    drive(1'b1, K1, K1[31:0], 8'h02);
    edge_check("round2", K2, 1'b1);
    drive(1'b1, K9, K9[31:0], 8'h36);
    edge_check("round10", K10, 1'b1);
    drive(1'b1, K0, K0[31:0], 8'h01);
    edge_check("gate_r1", K1, 1'b1);
    drive(1'b0, K1, K1[31:0], 8'h02);
    edge_check("gate_hold", K1, 1'b0);
    drive(1'b1, K1, K1[31:0], 8'h02);
    edge_check("gate_reenable", K2, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    chk("async_rst_key", key_o, 128'h0);
    chk("async_rst_valid", {127'h0, key_valid_o}, 128'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      drive(($urandom % 4) != 0, rk, ($urandom % 2) ? rk[31:0] : $urandom,
            ($urandom % 4) != 0 ? rc_tab[$urandom % 10] : 8'($urandom));
      if (i == 200) begin
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        chk("rand_async_rst_key", key_o, 128'h0);
        chk("rand_async_rst_valid", {127'h0, key_valid_o}, 128'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
      end
    end
    @(negedge clk_i);
    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
